// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
// The md_op encodings are also used by the E-stage controller that drives
// md_op/start and by the hazard unit that stalls MD-class instructions.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Result captured at launch and held until commit. we=0 means "leave HI/LO
  // alone" (divide by zero).
  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic md_is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit in the E stage. Holds architectural HI/LO.
// mult/multu/div/divu compute the result at launch, then keep busy high for
// a fixed latency and commit HI/LO on the last busy edge. mthi/mtlo write
// directly with no busy cycle.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start, md_op  - operation request (sampled only while not busy)
//   E_RD1, E_RD2  - rs / rt operand values from the D->E register
//   busy          - a mult/div is in flight
//   HI, LO        - architectural HI/LO registers
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,  // must be >= 1
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF    // must be >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_res_t     pend_q, pend_d, calc;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // ---------------------------------------------------------------------
  // Arithmetic on the current operands; only latched at a launch edge.
  // ---------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  always_comb begin
    prod_s = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
    prod_u = {32'b0, E_RD1} * {32'b0, E_RD2};
    calc   = '0;
    case (md_op)
      MD_MULT:  calc = '{we: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
      MD_MULTU: calc = '{we: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
      MD_DIV: begin
        if (E_RD2 == 32'd0) begin
          calc.we = 1'b0;
        end else if (E_RD1 == 32'h8000_0000 && E_RD2 == 32'hFFFF_FFFF) begin
          // Quotient overflows back to itself; handled explicitly so the
          // result doesn't depend on how the tool treats signed overflow.
          calc = '{we: 1'b1, hi: 32'd0, lo: 32'h8000_0000};
        end else begin
          calc.we = 1'b1;
          calc.lo = $signed(E_RD1) / $signed(E_RD2);
          calc.hi = $signed(E_RD1) % $signed(E_RD2);
        end
      end
      MD_DIVU: begin
        if (E_RD2 != 32'd0) begin
          calc.we = 1'b1;
          calc.lo = E_RD1 / E_RD2;
          calc.hi = E_RD1 % E_RD2;
        end
      end
      default: calc = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control: next state, countdown, HI/LO writes.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (md_is_mult(md_op)) begin
            pend_d  = calc;
            cnt_d   = CW'(MULT_CYCLES);
            state_d = S_RUN;
          end else if (md_is_div(md_op)) begin
            pend_d  = calc;
            cnt_d   = CW'(DIV_CYCLES);
            state_d = S_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = E_RD1;
          end else if (md_op == MD_MTLO) begin
            lo_d = E_RD1;
          end
          // reserved encodings fall through with no effect
        end
      end
      S_RUN: begin
        // start is ignored here; the hazard unit keeps it low while busy
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (pend_q.we) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
          pend_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] E_RD1, E_RD2;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int ignored_starts = 0;
  int cyc;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .E_RD1(E_RD1), .E_RD2(E_RD2), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // A start while busy is a protocol violation by the driver; record it.
  always @(posedge clk)
    if (!reset && start && busy) begin
      ignored_starts++;
      $display("note: start asserted while busy (ignored by design)");
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles until idle, bounded so a stuck busy still terminates.
  task automatic run_to_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; E_RD1 = a; E_RD2 = b;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0; E_RD1 = '0; E_RD2 = '0;
    step(); step();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // signed mult: -2 * 3 = -6
    launch(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    run_to_idle(cyc);
    check("mult_cycles", 32'(cyc), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // unsigned mult: (2^32-1)^2 = 0xFFFFFFFE_00000001
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_to_idle(cyc);
    check("multu_cycles", 32'(cyc), 32'd5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // signed div: -7 / 2 = -3 rem -1
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_to_idle(cyc);
    check("div_cycles", 32'(cyc), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // mthi then mtlo on consecutive cycles
    launch(MD_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", HI, 32'h0000_1234);
    check("mthi_lo_untouched", LO, 32'hFFFF_FFFD);
    launch(MD_MTLO, 32'h0000_5678, 32'd0);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_hi_untouched", HI, 32'h0000_1234);
    check("mtlo_lo", LO, 32'h0000_5678);

    // divu by zero: full latency, HI/LO untouched
    launch(MD_DIVU, 32'd99, 32'd0);
    check("divz_busy", 32'(busy), 32'd1);
    run_to_idle(cyc);
    check("divz_cycles", 32'(cyc), 32'd10);
    check("divz_hi", HI, 32'h0000_1234);
    check("divz_lo", LO, 32'h0000_5678);

    // signed divide overflow case
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_to_idle(cyc);
    check("divov_lo", LO, 32'h8000_0000);
    check("divov_hi", HI, 32'd0);

    // reserved op: no effect
    launch(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_hi", HI, 32'd0);
    check("rsvd_lo", LO, 32'h8000_0000);

    // reset in the third busy cycle of a mult: aborts, no later commit
    launch(MD_MULT, 32'd6, 32'd7);
    step(); step();
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    repeat (8) step();
    check("rst_mid_late_lo", LO, 32'd0);
    check("rst_mid_late_busy", 32'(busy), 32'd0);

    // back-to-back: div 100/7 with an illegal mtlo pulse while busy, then
    // multu 2*3 launched in the first idle cycle
    launch(MD_DIV, 32'd100, 32'd7);
    step(); step();
    launch(MD_MTLO, 32'hDEAD_0000, 32'd0);
    run_to_idle(cyc);
    check("b2b_div_cycles", 32'(cyc + 3), 32'd10);
    check("b2b_div_lo", LO, 32'd14);
    check("b2b_div_hi", HI, 32'd2);
    launch(MD_MULTU, 32'd2, 32'd3);
    check("b2b_multu_busy", 32'(busy), 32'd1);
    run_to_idle(cyc);
    check("b2b_multu_cycles", 32'(cyc), 32'd5);
    check("b2b_multu_hi", HI, 32'd0);
    check("b2b_multu_lo", LO, 32'd6);
    check("ignored_start_count", 32'(ignored_starts), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the operand values latched by the D→E pipeline register: rs value on `E_RD1`, rt value on `E_RD2`.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and writes mthi/mtlo directly. Holds the architectural HI/LO registers.
- Exports `busy` so the hazard unit can stall MD-class instructions in D, and the E-stage `clr` bubble logic can act on it.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  qualifies md_op this cycle; driven by E-stage decode
- md_op  input  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6/7 reserved
- E_RD1  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- E_RD2  input  32  rt operand (divisor / multiplier)
- busy  output  1  a mult/div is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- **Reset:** synchronous; at any posedge with reset=1, `busy`=0, `HI`=0, `LO`=0, counter=0, pending results cleared. Reset during an operation aborts it; no HI/LO commit occurs.
- **Start sampling:** `start` is sampled only when `busy`=0. If `start`=1 while `busy`=1, it is ignored; the hazard unit guarantees this never happens. The bench flags it as an assertion.
- **Mult/div launch:** at edge T with `start`=1, op in {0..3}, `busy`=0:
  - The result is computed from `E_RD1`/`E_RD2` as sampled at T and held internally.
  - counter ← N (MULT_CYCLES or DIV_CYCLES); `busy` ← 1.
- **Countdown:** at each edge with `busy`=1, the counter decrements.
- **Commit:** at the edge where counter==1:
  - `HI`/`LO` ← pending result, `busy` ← 0.
  - `busy` is high for exactly N cycles.
  - The new HI/LO are visible in the first cycle `busy`=0.
  - A new start is accepted in that same cycle.
- **MULT:** signed 32×32→64; HI=product[63:32], LO=product[31:0].
- **MULTU:** same, operands unsigned.
- **DIV:** signed; LO=quotient truncated toward zero, HI=remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU:** unsigned quotient/remainder.
- **Divide by zero (DIV or DIVU):** `busy` still runs DIV_CYCLES; HI and LO are left unchanged at commit.
- **MTHI/MTLO:** with `start`=1, `busy`=0, `HI` (or `LO`) ← `E_RD1` at that edge. No busy cycle; the value is visible next cycle. The other register is untouched.
- **Reserved md_op (6/7) with start:** no effect.
- **Reads:** `HI`/`LO` are plain register outputs. mfhi/mflo read them combinationally in E; the hazard unit stalls mfhi/mflo while `busy`=1 or `start`=1.
- **Clock gating:** no gated clock; all state on posedge `clk`.

Decomposition:
- Shared package holds:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - default latency constants
- The same encodings are consumed by the controller that drives `md_op`/`start` and by the hazard unit.
- Single module; arithmetic uses the native `*`, `/`, `%` operators on signed/unsigned 32-bit casts. No sub-module is warranted.

Test Plan:
- **Signed mult:** reset, then start MULT, `E_RD1`=0xFFFFFFFE, `E_RD2`=3 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Unsigned mult:** start MULTU, 0xFFFFFFFF × 0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- **Signed div:** start DIV, -7 (0xFFFFFFF9) / 2 → `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero:** MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → HI=0x1234, LO=0x5678, `busy` never set. Then DIVU x/0 → `busy` 10 cycles, HI/LO still 0x1234/0x5678.
- **Reset mid-operation:** start MULT 6×7, assert reset at cycle 3 of busy → next cycle `busy`=0, HI=LO=0; no later commit.
- **Back-to-back, start while busy:** start DIV 100/7; pulse start with MTLO during busy (assertion expected, ignored); start MULTU 2×3 in the first non-busy cycle → LO=14, HI=2 after the div. MULTU is accepted and ends with HI=0, LO=6 five cycles later.
